// File: rtl/bpsk_pkg.sv
// Shared types and sample encoding for the BPSK symbol serializer.
// Samples are two's complement: +1 = 1, -1 = all ones.
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [31:0] SYM_POS = 32'h0000_0001;
  localparam logic [31:0] SYM_NEG = 32'hFFFF_FFFF;

  // Low w bits hold the sample; callers truncate to their width.
  function automatic logic [31:0] sym_of(input logic b, input int w);
    logic [31:0] neg;
    neg = SYM_NEG >> (32 - w);
    return b ? neg : SYM_POS;
  endfunction

endpackage

// File: rtl/bpsk_sym_map.sv
// Maps one data bit to a signed BPSK sample, with optional
// differential encoding against the previous transmitted bit.
module bpsk_sym_map
  import bpsk_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DIFF  = 0
) (
  input  logic             bit_i,
  input  logic             prev_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             prev_o
);

  logic tx;

  assign tx     = (DIFF != 0) ? (bit_i ^ prev_i) : bit_i;
  assign sym_o  = SYM_W'(sym_of(tx, SYM_W));
  assign prev_o = (DIFF != 0) ? tx : prev_i;

endmodule

// File: rtl/bpsk_symbol_serializer.sv
// Serialises N-bit codewords LSB first into BPSK samples,
// each symbol repeated SPS times, valid/ready on both sides.
module bpsk_symbol_serializer
  import bpsk_pkg::*;
#(
  parameter int N     = 8,
  parameter int SYM_W = 2,
  parameter int SPS   = 4,
  parameter int DIFF  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_last,
  output logic             busy
);

  localparam int BW = $clog2(N) + 1;
  localparam int SW = $clog2(SPS) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);

  state_e state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] samp_q, samp_d;
  logic vld_q, vld_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic last_q, last_d;
  logic prev_q, prev_d;

  logic fire, wrap, accept;
  logic [N-1:0] shift;
  logic map_bit, map_prev;
  logic [SYM_W-1:0] map_sym;

  assign fire     = vld_q & out_ready;
  assign wrap     = fire & last_q;
  assign in_ready = (state_q == IDLE) | wrap;
  assign accept   = in_valid & in_ready;
  assign shift    = sreg_q >> 1;
  // A new word's first bit and the next bit of the current word never compete.
  assign map_bit  = in_ready ? in_data[0] : shift[0];

  bpsk_sym_map #(
    .SYM_W(SYM_W),
    .DIFF (DIFF)
  ) u_map (
    .bit_i (map_bit),
    .prev_i(prev_q),
    .sym_o (map_sym),
    .prev_o(map_prev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      vld_q   <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      vld_q   <= vld_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (wrap && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    bit_d  = bit_q;
    samp_d = samp_q;
    vld_d  = vld_q;
    sym_d  = sym_q;
    last_d = last_q;
    prev_d = prev_q;
    unique case (1'b1)
      accept: begin
        sreg_d = in_data;
        bit_d  = '0;
        samp_d = '0;
        vld_d  = 1'b1;
        sym_d  = map_sym;
        prev_d = map_prev;
        last_d = (BIT_LAST == '0) && (SAMP_LAST == '0);
      end
      (wrap && !accept): begin
        bit_d  = '0;
        samp_d = '0;
        vld_d  = 1'b0;
        sym_d  = '0;
        last_d = 1'b0;
      end
      (fire && !wrap): begin
        if (samp_q == SAMP_LAST) begin
          samp_d = '0;
          bit_d  = bit_q + BW'(1);
          sreg_d = shift;
          sym_d  = map_sym;
          prev_d = map_prev;
        end else begin
          samp_d = samp_q + SW'(1);
        end
        last_d = (bit_d == BIT_LAST) && (samp_d == SAMP_LAST);
      end
      default: ;
    endcase
  end

  assign out_valid = vld_q;
  assign out_sym   = sym_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_bpsk_symbol_serializer.sv
// Bench for bpsk_symbol_serializer: three parameterisations
// driven through one shared stimulus path and a bit-level model.
module tb_bpsk_symbol_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic drv_iv = 1'b0;
  logic [31:0] drv_data = '0;
  logic drv_rdy = 1'b1;

  logic iv0, ir0, ov0, or0, ol0, bz0;
  logic [7:0] id0;
  logic [1:0] os0;
  logic iv1, ir1, ov1, or1, ol1, bz1;
  logic [7:0] id1;
  logic [1:0] os1;
  logic iv2, ir2, ov2, or2, ol2, bz2;
  logic [14:0] id2;
  logic [3:0] os2;

  assign iv0 = (sel == 0) && drv_iv;
  assign iv1 = (sel == 1) && drv_iv;
  assign iv2 = (sel == 2) && drv_iv;
  assign id0 = drv_data[7:0];
  assign id1 = drv_data[7:0];
  assign id2 = drv_data[14:0];
  assign or0 = (sel == 0) ? drv_rdy : 1'b1;
  assign or1 = (sel == 1) ? drv_rdy : 1'b1;
  assign or2 = (sel == 2) ? drv_rdy : 1'b1;

  bpsk_symbol_serializer u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0),
    .out_sym(os0), .out_last(ol0), .busy(bz0)
  );

  bpsk_symbol_serializer #(.N(8), .SYM_W(2), .SPS(1), .DIFF(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_sym(os1), .out_last(ol1), .busy(bz1)
  );

  bpsk_symbol_serializer #(.N(15), .SYM_W(4), .SPS(2), .DIFF(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2),
    .out_sym(os2), .out_last(ol2), .busy(bz2)
  );

  logic o_iv, o_ir, o_ov, o_ol, o_bz;
  logic [31:0] o_sym;
  always_comb begin
    o_ir = ir0; o_ov = ov0; o_ol = ol0; o_bz = bz0;
    o_sym = 32'(os0);
    case (sel)
      1: begin
        o_ir = ir1; o_ov = ov1; o_ol = ol1; o_bz = bz1;
        o_sym = 32'(os1);
      end
      2: begin
        o_ir = ir2; o_ov = ov2; o_ol = ol2; o_bz = bz2;
        o_sym = 32'(os2);
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] pend[$];
  logic [32:0] expq[$];
  logic [32:0] gotq[$];
  bit mprev[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: one symbol per data bit, LSB first, SPS copies each.
  task automatic model_word(input logic [31:0] w);
    int n, sps, wd;
    bit diff, tx;
    logic [31:0] v;
    n = (sel == 2) ? 15 : 8;
    sps = (sel == 0) ? 4 : (sel == 1) ? 1 : 2;
    wd = (sel == 2) ? 4 : 2;
    diff = (sel == 1);
    for (int i = 0; i < n; i++) begin
      tx = w[i];
      if (diff) begin
        tx = tx ^ mprev[sel];
        mprev[sel] = tx;
      end
      v = tx ? ((32'd1 << wd) - 32'd1) : 32'd1;
      for (int s = 0; s < sps; s++)
        expq.push_back({v, (i == n - 1) && (s == sps - 1)});
    end
  endtask

  task automatic stream(input int rdy_pct, input int stop_at,
                        input bit chk_gap);
    int cyc, fires, first, lastc;
    bit fire, stalled, done;
    logic [32:0] held;
    cyc = 0; fires = 0; first = -1; lastc = -1;
    stalled = 0; done = 0; held = '0;
    expq.delete();
    gotq.delete();
    while (cyc < 4000 && !done) begin
      @(negedge clk);
      if (stalled) check("stall_stable", {o_sym, o_ol}, held);
      drv_rdy = ($urandom_range(99) < rdy_pct);
      drv_iv = (pend.size() > 0);
      drv_data = drv_iv ? pend[0] : $urandom;
      #1;
      fire = o_ov && drv_rdy;
      if (fire) begin
        gotq.push_back({o_sym, o_ol});
        fires++;
        if (first < 0) first = cyc;
        lastc = cyc;
        if (o_ol) check("in_ready_at_last", o_ir, 1);
      end
      if (drv_iv && o_ir) model_word(pend.pop_front());
      stalled = o_ov && !drv_rdy;
      held = {o_sym, o_ol};
      cyc++;
      if (stop_at >= 0 && fires == stop_at) done = 1;
      if (pend.size() == 0 && expq.size() > 0 &&
          gotq.size() == expq.size()) done = 1;
    end
    check("stream_done", done, 1);
    if (chk_gap) check("gapless", lastc - first + 1, fires);
    @(negedge clk);
    drv_iv = 1'b0;
    drv_rdy = 1'b1;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++) check({tag, "_sample"}, gotq[i], expq[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", o_ov, 0);
    check("rst_sym", o_sym, 0);
    check("rst_last", o_ol, 0);
    check("rst_busy", o_bz, 0);
    check("rst_in_ready", o_ir, 1);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    pend = '{32'hA5};
    stream(100, -1, 1);
    check("a5_count_const", gotq.size(), 32);
    compare("a5");

    pend = '{32'h00, 32'hFF};
    stream(100, -1, 1);
    check("b2b_count_const", gotq.size(), 64);
    compare("b2b");

    pend = '{32'hA5, $urandom, $urandom, $urandom};
    stream(50, -1, 0);
    compare("bp");

    for (int k = 0; k < 6; k++) pend.push_back($urandom);
    stream($urandom_range(30, 90), -1, 0);
    compare("rnd");

    sel = 1;
    pend = '{32'h01, 32'h00};
    stream(100, -1, 1);
    compare("diff");

    sel = 2;
    pend = '{32'h4001};
    stream(100, -1, 1);
    check("n15_count_const", gotq.size(), 30);
    compare("n15");
    pend = '{$urandom, $urandom};
    stream(70, -1, 0);
    compare("n15rnd");

    sel = 0;
    pend = '{32'h3C};
    stream(100, 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_ov, 0);
    check("mid_rst_sym", o_sym, 0);
    check("mid_rst_last", o_ol, 0);
    check("mid_rst_busy", o_bz, 0);
    mprev = '{0, 0, 0};
    pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", o_ir, 1);
    pend = '{32'hA5};
    stream(100, -1, 1);
    compare("post_rst");

    sel = 1;
    pend = '{32'h00};
    stream(100, -1, 1);
    compare("diff_prev_clr");
    check("diff_prev_clr_pos", gotq.size() > 0 ? gotq[0] : 33'h0,
          {32'd1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
